// File: rtl/bcd_seq_pkg.sv
// Shared definitions for the sequential double-dabble converter: state
// encoding, BCD digit width and the minimum digit count for a binary width.
package bcd_seq_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_CONV = 1'b1;
  localparam int   BCD_W   = 4;

  typedef enum logic {
    IDLE = ST_IDLE,
    CONV = ST_CONV
  } state_t;

  // Decimal digits needed to print 2^width-1.
  function automatic int min_digits(input int width);
    longint unsigned v;
    int n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n++;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Add-3 correction cell for one BCD digit; out-of-range codes collapse to 0.
module bcd_digit_adj
  import bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] i_d,
  output logic [BCD_W-1:0] o_d
);

  always_comb begin
    o_d = i_d;
    if (i_d >= 4'd10)     o_d = '0;
    else if (i_d >= 4'd5) o_d = i_d + 4'd3;
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter: one add-3/shift step per clock, WIDTH
// steps per conversion, handshaked with start/busy/done.
module bcd_seq_converter
  import bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd
);

  localparam int            BW   = BCD_W * DIGITS;
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "bcd_seq_converter: WIDTH %0d outside 4..16", WIDTH);
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $fatal(1, "bcd_seq_converter: DIGITS %0d too small for WIDTH %0d", DIGITS, WIDTH);
  end

  state_t          r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_scr;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .i_d (r_scr[g*BCD_W +: BCD_W]),
      .o_d (w_adj[g*BCD_W +: BCD_W])
    );
  end

  // Corrected scratch shifted left, binary MSB entering the ones digit.
  assign w_shift = {w_adj[BW-2:0], r_bin[WIDTH-1]};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_scr   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_scr <= w_shift;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            bcd     <= w_shift;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed + random bench for bcd_seq_converter (8-bit and 16-bit builds)
// against a decimal-arithmetic reference.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  bin8;
  logic [15:0] bin16;
  logic        busy8, done8, busy16, done16;
  logic [11:0] bcd8;
  logic [19:0] bcd16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut8 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8)
  );

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut16 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16)
  );

  function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 8-bit conversion with exact latency: done only after the 8th edge.
  task automatic conv8(input logic [7:0] v, input string tag);
    int early;
    early = 0;
    bin8 = v; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, "/busy_after_accept"}, 32'(busy8), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (done8 || !busy8) early++;
    end
    chk({tag, "/early_done"}, early, 0);
    tick();
    chk({tag, "/done"}, 32'(done8), 32'd1);
    chk({tag, "/busy_in_done"}, 32'(busy8), 32'd0);
    chk({tag, "/bcd"}, 32'(bcd8), ref_bcd(v, 3));
    tick();
    chk({tag, "/done_one_cycle"}, 32'(done8), 32'd0);
  endtask

  task automatic conv16(input logic [15:0] v, input string tag);
    bin16 = v; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    chk({tag, "/not_yet"}, 32'(done16), 32'd0);
    tick();
    chk({tag, "/done"}, 32'(done16), 32'd1);
    chk({tag, "/bcd"}, 32'(bcd16), ref_bcd(v, 5));
    tick();
  endtask

  initial begin
    int pulses, first_at, second_at;
    logic [7:0] rv;

    rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
    #3;
    chk("reset/busy", 32'(busy8), 32'd0);
    chk("reset/done", 32'(done8), 32'd0);
    chk("reset/bcd", 32'(bcd8), 32'd0);
    chk("reset/bcd16", 32'(bcd16), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    conv8(8'd0,   "zero");
    conv8(8'd255, "max");
    conv8(8'd16,  "sixteen");
    conv8(8'd99,  "ninety_nine");
    conv8(8'd100, "hundred");

    // Second start mid-conversion must be ignored.
    bin8 = 8'd200; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    pulses = 0; first_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 4) begin bin8 = 8'd7; start8 = 1'b1; end
      if (i == 5) start8 = 1'b0;
      tick();
      if (done8) begin pulses++; if (first_at == 0) first_at = i; end
    end
    chk("ignore/pulses", pulses, 1);
    chk("ignore/latency", first_at, 8);
    chk("ignore/bcd", 32'(bcd8), 32'h200);

    // Asynchronous reset mid-conversion clears outputs before the next edge.
    bin8 = 8'd123; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("async/busy", 32'(busy8), 32'd0);
    chk("async/done", 32'(done8), 32'd0);
    chk("async/bcd", 32'(bcd8), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    conv8(8'd45, "after_reset");

    // start held high: period WIDTH+1, bin changed during the done cycle.
    bin8 = 8'd37; start8 = 1'b1;
    tick();
    first_at = 0; second_at = 0; pulses = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (done8) begin
        pulses++;
        if (first_at == 0) begin
          first_at = i;
          chk("held/first_bcd", 32'(bcd8), 32'h037);
          bin8 = 8'd142;
        end else begin
          second_at = i;
          chk("held/second_bcd", 32'(bcd8), 32'h142);
          start8 = 1'b0;
        end
      end
    end
    chk("held/pulses", pulses, 2);
    chk("held/period", second_at - first_at, 9);
    tick();

    for (int n = 0; n < 12; n++) begin
      rv = 8'($urandom_range(0, 255));
      conv8(rv, $sformatf("rand8_%0d", rv));
    end

    conv16(16'd65535, "w16_max");
    conv16(16'd0,     "w16_zero");
    for (int n = 0; n < 4; n++) begin
      logic [15:0] v16;
      v16 = 16'($urandom_range(0, 65535));
      conv16(v16, $sformatf("rand16_%0d", v16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
